// File: rtl/calendar_pkg.sv
// calendar_pkg: month/day-of-week constants and Gregorian helper functions
package calendar_pkg;
    localparam logic [3:0] JAN = 4'd1, FEB = 4'd2, MAR = 4'd3, APR = 4'd4, MAY = 4'd5, JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7, AUG = 4'd8, SEP = 4'd9, OCT = 4'd10, NOV = 4'd11, DEC = 4'd12;
    localparam logic [2:0] DOW_SUN = 3'd0, DOW_MON = 3'd1, DOW_TUE = 3'd2, DOW_WED = 3'd3;
    localparam logic [2:0] DOW_THU = 3'd4, DOW_FRI = 3'd5, DOW_SAT = 3'd6;

    function automatic logic is_leap(input int unsigned y);
        return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        return (m == FEB) ? (leap ? 5'd29 : 5'd28) :
               (m == APR || m == JUN || m == SEP || m == NOV) ? 5'd30 : 5'd31;
    endfunction
endpackage

// File: rtl/cal_dim_lookup.sv
// cal_dim_lookup: days in the given month of the given year
module cal_dim_lookup
    import calendar_pkg::*;
#(
    parameter int YEAR_W = 12
) (
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [4:0]        dim
);
    assign dim = days_in_month(month, is_leap(32'(year)));
endmodule

// File: rtl/calendar_gregorian.sv
// calendar_gregorian: Gregorian date with validated load, adjust, rollover pulses; CAL_DOW_EN enables the day-of-week counter
module calendar_gregorian
    import calendar_pkg::*;
#(
    parameter int YEAR_W        = 12,
    parameter int YEAR_MIN      = 2000,
    parameter int YEAR_MAX      = 2099,
    parameter int DEFAULT_DAY   = 1,
    parameter int DEFAULT_MONTH = 9,
    parameter int DEFAULT_YEAR  = 2023,
    parameter int DEFAULT_DOW   = 5
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic              end_of_day,
    input  logic              inc_day,
    input  logic              inc_month,
    input  logic              inc_year,
    input  logic              adj_dec,
    input  logic              load_valid,
    input  logic [4:0]        load_day,
    input  logic [3:0]        load_month,
    input  logic [YEAR_W-1:0] load_year,
    input  logic [2:0]        load_dow,
    output logic [4:0]        day,
    output logic [3:0]        month,
    output logic [YEAR_W-1:0] year,
    output logic [2:0]        dow,
    output logic              leap_year,
    output logic              month_rollover,
    output logic              year_rollover,
    output logic              load_err
);
    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);

    logic [4:0]        dim, cand_dim, day_adj, day_clamp;
    logic [3:0]        month_adj, cand_month;
    logic [YEAR_W-1:0] year_inc, year_adj, cand_year;
    logic              load_ok, adjust, eod_go;

    assign year_inc   = (year >= Y_MAX) ? Y_MIN : year + YEAR_W'(1);
    assign year_adj   = adj_dec ? ((year <= Y_MIN) ? Y_MAX : year - YEAR_W'(1)) : year_inc;
    assign month_adj  = adj_dec ? ((month <= JAN) ? DEC : month - 4'd1) : ((month >= DEC) ? JAN : month + 4'd1);
    assign day_adj    = adj_dec ? ((day <= 5'd1) ? dim : day - 5'd1) : ((day >= dim) ? 5'd1 : day + 5'd1);
    // The second lookup sees whichever date would be written: the load request or the adjusted month/year
    assign cand_month = load_valid ? load_month : inc_month ? month_adj : month;
    assign cand_year  = load_valid ? load_year : (inc_year && !inc_month) ? year_adj : year;
    assign day_clamp  = (day > cand_dim) ? cand_dim : day;
    assign adjust     = inc_day | inc_month | inc_year;
    assign eod_go     = !load_valid && !adjust && end_of_day;
    assign leap_year  = is_leap(32'(year));

    assign load_ok = load_month >= JAN && load_month <= DEC && load_day >= 5'd1 && load_day <= cand_dim &&
                     load_year >= Y_MIN && load_year <= Y_MAX
`ifdef CAL_DOW_EN
                     && load_dow <= DOW_SAT
`endif
                     ;

    cal_dim_lookup #(.YEAR_W(YEAR_W)) u_dim_cur  (.month(month),      .year(year),      .dim(dim));
    cal_dim_lookup #(.YEAR_W(YEAR_W)) u_dim_cand (.month(cand_month), .year(cand_year), .dim(cand_dim));

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            day            <= 5'(DEFAULT_DAY);
            month          <= 4'(DEFAULT_MONTH);
            year           <= YEAR_W'(DEFAULT_YEAR);
            month_rollover <= 1'b0;
            year_rollover  <= 1'b0;
            load_err       <= 1'b0;
        end else begin
            month_rollover <= 1'b0;
            year_rollover  <= 1'b0;
            load_err       <= 1'b0;
            if (load_valid) begin
                if (load_ok) begin
                    day   <= load_day;
                    month <= load_month;
                    year  <= load_year;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (inc_day) begin
                day <= day_adj;
            end else if (inc_month || inc_year) begin
                month <= cand_month;
                year  <= cand_year;
                day   <= day_clamp;
            end else if (end_of_day) begin
                if (day >= dim) begin
                    day            <= 5'd1;
                    month_rollover <= 1'b1;
                    month          <= (month >= DEC) ? JAN : month + 4'd1;
                    if (month >= DEC) begin
                        year          <= year_inc;
                        year_rollover <= 1'b1;
                    end
                end else begin
                    day <= day + 5'd1;
                end
            end
        end
    end

`ifdef CAL_DOW_EN
    always_ff @(posedge clk_100MHz) begin
        if (reset) dow <= 3'(DEFAULT_DOW);
        else if (load_valid && load_ok) dow <= load_dow;
        else if (eod_go) dow <= (dow >= DOW_SAT) ? DOW_SUN : dow + 3'd1;
    end
`else
    logic [2:0] unused_load_dow;
    assign unused_load_dow = load_dow;
    assign dow = DOW_SUN;
`endif
endmodule

// File: tb/tb_calendar_gregorian.sv
// tb_calendar_gregorian: directed checks of reset, rollovers, adjust clamping, load rejection and priority
module tb_calendar_gregorian;
    logic        clk_100MHz = 1'b0, reset = 1'b0, end_of_day = 1'b0;
    logic        inc_day = 1'b0, inc_month = 1'b0, inc_year = 1'b0, adj_dec = 1'b0, load_valid = 1'b0;
    logic [4:0]  load_day = '0;
    logic [3:0]  load_month = '0;
    logic [11:0] load_year = '0;
    logic [2:0]  load_dow = '0;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [11:0] year;
    logic [2:0]  dow;
    logic        leap_year, month_rollover, year_rollover, load_err;
    int total = 0, bad = 0;

    always #5 clk_100MHz = ~clk_100MHz;

    calendar_gregorian dut (
        .clk_100MHz(clk_100MHz), .reset(reset), .end_of_day(end_of_day),
        .inc_day(inc_day), .inc_month(inc_month), .inc_year(inc_year), .adj_dec(adj_dec),
        .load_valid(load_valid), .load_day(load_day), .load_month(load_month),
        .load_year(load_year), .load_dow(load_dow),
        .day(day), .month(month), .year(year), .dow(dow), .leap_year(leap_year),
        .month_rollover(month_rollover), .year_rollover(year_rollover), .load_err(load_err)
    );

    function automatic logic [2:0] ed(input logic [2:0] w);
`ifdef CAL_DOW_EN
        return w;
`else
        return 3'd0 & w;
`endif
    endfunction

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic load(input int d, input int m, input int y, input int w);
        load_day = 5'(d); load_month = 4'(m); load_year = 12'(y); load_dow = 3'(w);
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic eod();
        end_of_day = 1'b1;
        tick();
        end_of_day = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++; if ({day, month, year} !== {5'd1, 4'd9, 12'd2023}) begin bad++; $display("FAIL reset_date got %0d/%0d/%0d want 1/9/2023", day, month, year); end
        total++; if (dow !== ed(3'd5)) begin bad++; $display("FAIL reset_dow got %0d want %0d", dow, ed(3'd5)); end
        total++; if ({month_rollover, year_rollover, load_err} !== 3'b000) begin bad++; $display("FAIL reset_pulses got %b want 000", {month_rollover, year_rollover, load_err}); end
        total++; if (leap_year !== 1'b0) begin bad++; $display("FAIL reset_leap got %b want 0", leap_year); end
    endtask

    task automatic test_leap_rollover();
        load(28, 2, 2023, 2);
        total++; if ({day, month, year, load_err} !== {5'd28, 4'd2, 12'd2023, 1'b0}) begin bad++; $display("FAIL load_feb23 got %0d/%0d/%0d err=%b", day, month, year, load_err); end
        eod();
        total++; if ({day, month, year} !== {5'd1, 4'd3, 12'd2023}) begin bad++; $display("FAIL eod_feb23 got %0d/%0d/%0d want 1/3/2023", day, month, year); end
        total++; if ({month_rollover, year_rollover} !== 2'b10) begin bad++; $display("FAIL eod_feb23_pulse got %b want 10", {month_rollover, year_rollover}); end
        total++; if (dow !== ed(3'd3)) begin bad++; $display("FAIL eod_feb23_dow got %0d want %0d", dow, ed(3'd3)); end
        tick();
        total++; if (month_rollover !== 1'b0) begin bad++; $display("FAIL mro_one_cycle got %b want 0", month_rollover); end
        load(28, 2, 2000, 1);
        total++; if (leap_year !== 1'b1) begin bad++; $display("FAIL leap_2000 got %b want 1", leap_year); end
        eod();
        total++; if ({day, month, year, month_rollover} !== {5'd29, 4'd2, 12'd2000, 1'b0}) begin bad++; $display("FAIL eod_feb00 got %0d/%0d/%0d mro=%b want 29/2/2000 0", day, month, year, month_rollover); end
        eod();
        total++; if ({day, month, month_rollover} !== {5'd1, 4'd3, 1'b1}) begin bad++; $display("FAIL eod_feb29 got %0d/%0d mro=%b want 1/3 1", day, month, month_rollover); end
        load(1, 1, 2100 - 200, 0);
        total++; if (load_err !== 1'b1) begin bad++; $display("FAIL load_1900 err got %b want 1", load_err); end
        load(1, 3, 2002, 5);
        total++; if (leap_year !== 1'b0) begin bad++; $display("FAIL leap_2002 got %b want 0", leap_year); end
    endtask

    task automatic test_year_wrap();
        load(31, 12, 2099, 4);
        eod();
        total++; if ({day, month, year} !== {5'd1, 4'd1, 12'd2000}) begin bad++; $display("FAIL year_wrap got %0d/%0d/%0d want 1/1/2000", day, month, year); end
        total++; if ({month_rollover, year_rollover} !== 2'b11) begin bad++; $display("FAIL year_wrap_pulse got %b want 11", {month_rollover, year_rollover}); end
        total++; if (dow !== ed(3'd5)) begin bad++; $display("FAIL year_wrap_dow got %0d want %0d", dow, ed(3'd5)); end
        tick();
        total++; if ({month_rollover, year_rollover} !== 2'b00) begin bad++; $display("FAIL year_wrap_clear got %b want 00", {month_rollover, year_rollover}); end
        load(30, 6, 2030, 6);
        eod();
        total++; if ({day, month, dow} !== {5'd1, 4'd7, ed(3'd0)}) begin bad++; $display("FAIL jun30 got %0d/%0d dow=%0d want 1/7 %0d", day, month, dow, ed(3'd0)); end
    endtask

    task automatic test_clamp();
        load(31, 1, 2024, 3);
        inc_month = 1'b1; tick(); inc_month = 1'b0;
        total++; if ({day, month, year} !== {5'd29, 4'd2, 12'd2024}) begin bad++; $display("FAIL clamp_month got %0d/%0d/%0d want 29/2/2024", day, month, year); end
        total++; if ({month_rollover, year_rollover, dow} !== {2'b00, ed(3'd3)}) begin bad++; $display("FAIL adj_side got mro=%b yro=%b dow=%0d", month_rollover, year_rollover, dow); end
        adj_dec = 1'b1; inc_year = 1'b1; tick(); inc_year = 1'b0;
        total++; if ({day, month, year} !== {5'd28, 4'd2, 12'd2023}) begin bad++; $display("FAIL clamp_year got %0d/%0d/%0d want 28/2/2023", day, month, year); end
        adj_dec = 1'b0; inc_day = 1'b1; tick(); inc_day = 1'b0;
        total++; if ({day, month, year} !== {5'd1, 4'd2, 12'd2023}) begin bad++; $display("FAIL day_wrap_up got %0d/%0d/%0d want 1/2/2023", day, month, year); end
        adj_dec = 1'b1; inc_day = 1'b1; tick(); inc_day = 1'b0;
        total++; if ({day, month} !== {5'd28, 4'd2}) begin bad++; $display("FAIL day_wrap_dn got %0d/%0d want 28/2", day, month); end
        load(15, 1, 2050, 2);
        inc_month = 1'b1; tick(); inc_month = 1'b0;
        total++; if ({day, month, year} !== {5'd15, 4'd12, 12'd2050}) begin bad++; $display("FAIL month_wrap_dn got %0d/%0d/%0d want 15/12/2050", day, month, year); end
        adj_dec = 1'b0; inc_month = 1'b1; tick(); inc_month = 1'b0;
        total++; if ({month, year} !== {4'd1, 12'd2050}) begin bad++; $display("FAIL month_wrap_up got %0d/%0d want 1/2050", month, year); end
        load(10, 3, 2000, 1);
        adj_dec = 1'b1; inc_year = 1'b1; tick(); inc_year = 1'b0;
        total++; if (year !== 12'd2099) begin bad++; $display("FAIL year_wrap_dn got %0d want 2099", year); end
        adj_dec = 1'b0; inc_year = 1'b1; tick(); inc_year = 1'b0;
        total++; if ({day, month, year} !== {5'd10, 4'd3, 12'd2000}) begin bad++; $display("FAIL year_wrap_up got %0d/%0d/%0d want 10/3/2000", day, month, year); end
    endtask

    task automatic test_load_reject();
        load(15, 6, 2023, 4);
        load(31, 4, 2023, 1);
        total++; if ({load_err, day, month, year} !== {1'b1, 5'd15, 4'd6, 12'd2023}) begin bad++; $display("FAIL rej_apr31 err=%b got %0d/%0d/%0d", load_err, day, month, year); end
        load(0, 5, 2023, 1);
        total++; if ({load_err, day, month, year} !== {1'b1, 5'd15, 4'd6, 12'd2023}) begin bad++; $display("FAIL rej_day0 err=%b got %0d/%0d/%0d", load_err, day, month, year); end
        load(1, 1, 2100, 1);
        total++; if ({load_err, day, month, year} !== {1'b1, 5'd15, 4'd6, 12'd2023}) begin bad++; $display("FAIL rej_2100 err=%b got %0d/%0d/%0d", load_err, day, month, year); end
        load(29, 2, 2023, 1);
        total++; if ({load_err, day, month} !== {1'b1, 5'd15, 4'd6}) begin bad++; $display("FAIL rej_feb29 err=%b got %0d/%0d", load_err, day, month); end
        load(1, 13, 2023, 1);
        total++; if ({load_err, month} !== {1'b1, 4'd6}) begin bad++; $display("FAIL rej_m13 err=%b month=%0d", load_err, month); end
        tick();
        total++; if (load_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got %b want 0", load_err); end
        load(2, 7, 2023, 7);
`ifdef CAL_DOW_EN
        total++; if ({load_err, day} !== {1'b1, 5'd15}) begin bad++; $display("FAIL rej_dow7 err=%b day=%0d want 1 15", load_err, day); end
`else
        total++; if ({load_err, day, dow} !== {1'b0, 5'd2, 3'd0}) begin bad++; $display("FAIL dow7_ignored err=%b day=%0d dow=%0d want 0 2 0", load_err, day, dow); end
`endif
    endtask

    task automatic test_simultaneous();
        end_of_day = 1'b1;
        load(10, 10, 2030, 3);
        end_of_day = 1'b0;
        total++; if ({day, month, year, dow} !== {5'd10, 4'd10, 12'd2030, ed(3'd3)}) begin bad++; $display("FAIL load_vs_eod got %0d/%0d/%0d dow=%0d", day, month, year, dow); end
        end_of_day = 1'b1; inc_day = 1'b1; tick(); end_of_day = 1'b0; inc_day = 1'b0;
        total++; if ({day, dow} !== {5'd11, ed(3'd3)}) begin bad++; $display("FAIL adj_vs_eod got day=%0d dow=%0d want 11 %0d", day, dow, ed(3'd3)); end
        inc_day = 1'b1; inc_month = 1'b1; tick(); inc_day = 1'b0; inc_month = 1'b0;
        total++; if ({day, month} !== {5'd12, 4'd10}) begin bad++; $display("FAIL day_vs_month got %0d/%0d want 12/10", day, month); end
        eod();
        total++; if ({day, dow} !== {5'd13, ed(3'd4)}) begin bad++; $display("FAIL plain_eod got day=%0d dow=%0d want 13 %0d", day, dow, ed(3'd4)); end
        reset = 1'b1;
        load(5, 5, 2050, 1);
        reset = 1'b0;
        total++; if ({day, month, year, dow} !== {5'd1, 4'd9, 12'd2023, ed(3'd5)}) begin bad++; $display("FAIL reset_vs_load got %0d/%0d/%0d dow=%0d", day, month, year, dow); end
    endtask

    initial begin
        test_reset();
        test_leap_rollover();
        test_year_wrap();
        test_clamp();
        test_load_reject();
        test_simultaneous();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
